// File: rtl/gouram_trace_merge.sv
// gouram_trace_merge
// Multi-channel trace record merger. Completed trace records from
// NUM_CHANNELS trackers are arbitrated round-robin, stamped with a shared
// free-running cycle timestamp and buffered in a FIFO with a valid/ready
// output. Per-channel tight-loop detection either locks capture (one-shot
// mode) or drops the repeated records (continuous mode).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ch_valid/addr/data    per-channel record inputs (packed, channel i at slice i)
//   ch_ready              one-hot accept for the current cycle
//   mode_oneshot          1 = lock on repeat, 0 = suppress repeats
//   unlock                pulse: clear lock and all run counters
//   out_valid/out_ready   FIFO head handshake
//   out_addr/data/chan/ts head record fields
//   capture_enable, lock  capture status
//   stall_cycles          saturating count of cycles a valid channel was refused
//   timestamp             current cycle counter
module gouram_trace_merge #(
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_WIDTH     = 32,
  parameter int REPEAT_LIMIT = 4,
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            ch_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  input  logic                               mode_oneshot,
  input  logic                               unlock,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ADDR_WIDTH-1:0]              out_addr,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CHW-1:0]                     out_chan,
  output logic [TS_WIDTH-1:0]                out_ts,
  output logic                               capture_enable,
  output logic                               lock,
  output logic [15:0]                        stall_cycles,
  output logic [TS_WIDTH-1:0]                timestamp
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REPEAT_LIMIT + 1);

  typedef enum logic {ST_CAPTURE, ST_LOCKED} state_t;
  state_t state, state_nxt;

  logic [CHW-1:0]        rr_ptr;
  logic [CHW-1:0]        grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] sel_last;
  logic [RW-1:0]         sel_run;
  logic [RW-1:0]         run_new;
  logic                  repeat_hit;
  logic                  can_push;
  logic                  push;
  logic                  pop;
  logic                  lock_evt;

  logic [RW-1:0]         run       [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] last_addr [NUM_CHANNELS];

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CHW-1:0]        mem_chan [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;

  assign capture_enable = (state == ST_CAPTURE);
  assign lock           = (state == ST_LOCKED);
  assign out_valid      = (count != '0);
  assign pop            = out_valid && out_ready;
  assign can_push       = capture_enable && ((count < (PW+1)'(FIFO_DEPTH)) || pop);

  // Round-robin: first pass covers channels at/after rr_ptr, second pass
  // wraps to the lower channels; this avoids a modulo on the index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_last  = '0;
    sel_run   = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (!grant_any && can_push && ch_valid[i] && (CHW'(i) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = CHW'(i);
        sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = last_addr[i];
        sel_run   = run[i];
      end
    end
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (!grant_any && can_push && ch_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = CHW'(i);
        sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = last_addr[i];
        sel_run   = run[i];
      end
    end
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      ch_ready[i] = grant_any && (grant_idx == CHW'(i));
    end
  end

  always_comb begin
    run_new = RW'(1);
    if (sel_addr == sel_last) begin
      run_new = (sel_run >= RW'(REPEAT_LIMIT)) ? RW'(REPEAT_LIMIT) : sel_run + RW'(1);
    end
    repeat_hit = (run_new == RW'(REPEAT_LIMIT));
    // Continuous mode still handshakes a repeated record but never stores it.
    push       = grant_any && !(!mode_oneshot && repeat_hit);
    lock_evt   = grant_any && mode_oneshot && repeat_hit;
  end

  always_comb begin
    state_nxt = state;
    if (unlock) begin
      state_nxt = ST_CAPTURE;
    end else if (lock_evt) begin
      state_nxt = ST_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_CAPTURE;
      rr_ptr       <= '0;
      timestamp    <= '0;
      stall_cycles <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        run[i]       <= '0;
        last_addr[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      timestamp <= timestamp + TS_WIDTH'(1);
      if (|ch_valid && !can_push && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (grant_any) begin
        rr_ptr <= (grant_idx == CHW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CHW'(1);
      end
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (unlock) begin
          run[i] <= '0;
        end else if (grant_any && (grant_idx == CHW'(i))) begin
          run[i] <= run_new;
        end
        if (grant_any && (grant_idx == CHW'(i))) begin
          last_addr[i] <= sel_addr;
        end
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= sel_addr;
      mem_data[wr_ptr] <= sel_data;
      mem_chan[wr_ptr] <= grant_idx;
      mem_ts[wr_ptr]   <= timestamp;
    end
  end

  assign out_addr = mem_addr[rd_ptr];
  assign out_data = mem_data[rd_ptr];
  assign out_chan = mem_chan[rd_ptr];
  assign out_ts   = mem_ts[rd_ptr];

endmodule

// File: tb/tb_gouram_trace_merge.sv
// Directed bench for gouram_trace_merge. Stimulus pushes hand-derived
// expected records into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT head is handed over (out_valid && out_ready).
module tb_gouram_trace_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_valid;
  logic [31:0] ch_addr;
  logic [63:0] ch_data;
  logic [1:0]  ch_ready;
  logic        mode_oneshot;
  logic        unlock;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [31:0] out_data;
  logic [0:0]  out_chan;
  logic [31:0] out_ts;
  logic        capture_enable;
  logic        lock;
  logic [15:0] stall_cycles;
  logic [31:0] timestamp;

  always #5 clk = ~clk;

  gouram_trace_merge #(
    .NUM_CHANNELS(2),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8),
    .TS_WIDTH(32),
    .REPEAT_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_addr(ch_addr), .ch_data(ch_data), .ch_ready(ch_ready),
    .mode_oneshot(mode_oneshot), .unlock(unlock),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_chan(out_chan), .out_ts(out_ts),
    .capture_enable(capture_enable), .lock(lock),
    .stall_cycles(stall_cycles), .timestamp(timestamp)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [0:0]  c;
    logic [31:0] ts;
  } rec_t;

  rec_t        sb[$];
  rec_t        mon_got, mon_exp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_ts;

  // Reference cycle count: cleared by reset, +1 per clock otherwise.
  always @(posedge clk) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  function automatic logic [31:0] mkdata(input int ch, input logic [15:0] a);
    return {4'hA, 4'(ch), 8'h5C, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_rec(input int ch, input logic [15:0] a, input logic [31:0] ts);
    rec_t r;
    r.a  = a;
    r.d  = mkdata(ch, a);
    r.c  = 1'(ch);
    r.ts = ts;
    sb.push_back(r);
  endtask

  // Called at a negedge: drive one cycle of channel inputs, sample ch_ready
  // and the reference timestamp for that cycle, return at the next negedge.
  task automatic step(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1,
                      output logic [1:0] rdy, output logic [31:0] ts);
    ch_valid = v;
    ch_addr  = {a1, a0};
    ch_data  = {mkdata(1, a1), mkdata(0, a0)};
    #1;
    rdy = ch_ready;
    ts  = tb_ts;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_valid = '0;
    unlock   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    ch_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain actual=%0d_left required=0_left", sb.size());
    end
    @(negedge clk);
  endtask

  // Monitor: compares each record as it leaves the FIFO.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      mon_got = {out_addr, out_data, out_chan, out_ts};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected actual=%0h required=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL rec actual=%0h required=%0h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rdy;
    logic [31:0] ts;
    logic [15:0] a0, a1;

    rst_n = 1'b0; ch_valid = '0; ch_addr = '0; ch_data = '0;
    mode_oneshot = 1'b0; unlock = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // 1: reset state and single-record latency/timestamp
    do_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lock", lock, 0);
    chk("rst_capture_enable", capture_enable, 1);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_timestamp", timestamp, 0);
    chk("rst_ch_ready", ch_ready, 0);
    while (tb_ts != 32'd5) @(negedge clk);
    step(2'b01, 16'h0100, 16'h0000, rdy, ts);
    ch_valid = '0;
    chk("t1_ready", rdy, 2'b01);
    exp_rec(0, 16'h0100, 32'd5);
    chk("t1_out_valid_next", out_valid, 1);
    chk("t1_timestamp", timestamp, 6);
    chk("t1_stall", stall_cycles, 0);
    drain();

    // 2: round-robin alternation between two busy channels
    do_reset();
    a0 = 16'h2000; a1 = 16'h2100;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, a0, a1, rdy, ts);
      if (k % 2 == 0) begin
        chk("t2_grant", rdy, 2'b01);
        exp_rec(0, a0, ts);
        a0 = a0 + 16'd1;
      end else begin
        chk("t2_grant", rdy, 2'b10);
        exp_rec(1, a1, ts);
        a1 = a1 + 16'd1;
      end
    end
    drain();

    // 3: full FIFO, stall counting, push+pop on full
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(2'b01, 16'h1000 + 16'(k), 16'h0000, rdy, ts);
      chk("t3_fill_ready", rdy, 2'b01);
      exp_rec(0, 16'h1000 + 16'(k), ts);
    end
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 16'h1008, 16'h0000, rdy, ts);
      chk("t3_full_ready", rdy, 2'b00);
      chk("t3_stall", stall_cycles, 64'(k + 1));
    end
    out_ready = 1'b1;
    step(2'b01, 16'h1008, 16'h0000, rdy, ts);
    out_ready = 1'b0;
    chk("t3_pushpop_ready", rdy, 2'b01);
    exp_rec(0, 16'h1008, ts);
    chk("t3_stall_hold", stall_cycles, 3);
    step(2'b01, 16'h1009, 16'h0000, rdy, ts);
    chk("t3_still_full", rdy, 2'b00);
    drain();

    // 4: one-shot lock, refusal while locked, unlock restart
    do_reset();
    mode_oneshot = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 16'h0000, 16'h0200, rdy, ts);
      chk("t4_ready", rdy, 2'b10);
      exp_rec(1, 16'h0200, ts);
      if (k < 3) chk("t4_lock_early", lock, 0);
    end
    ch_valid = '0;
    chk("t4_lock", lock, 1);
    chk("t4_capture_enable", capture_enable, 0);
    for (int k = 0; k < 2; k++) begin
      step(2'b01, 16'h0500, 16'h0000, rdy, ts);
      chk("t4_locked_ready", rdy, 2'b00);
    end
    unlock = 1'b1;
    step(2'b00, 16'h0000, 16'h0000, rdy, ts);
    unlock = 1'b0;
    chk("t4_unlock_lock", lock, 0);
    chk("t4_unlock_ce", capture_enable, 1);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 16'h0000, 16'h0200, rdy, ts);
      chk("t4_resume_ready", rdy, 2'b10);
      exp_rec(1, 16'h0200, ts);
    end
    ch_valid = '0;
    chk("t4_resume_lock", lock, 0);
    drain();

    // 5: continuous mode suppression
    do_reset();
    mode_oneshot = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(2'b01, 16'h0300, 16'h0000, rdy, ts);
      chk("t5_ready", rdy, 2'b01);
      if (k < 3) exp_rec(0, 16'h0300, ts);
    end
    chk("t5_lock", lock, 0);
    step(2'b01, 16'h0304, 16'h0000, rdy, ts);
    ch_valid = '0;
    chk("t5_new_ready", rdy, 2'b01);
    exp_rec(0, 16'h0304, ts);
    drain();

    // 6: reset mid-operation flushes FIFO and lock
    do_reset();
    mode_oneshot = 1'b1;
    out_ready = 1'b0;
    step(2'b01, 16'h0100, 16'h0000, rdy, ts);
    for (int k = 0; k < 4; k++) step(2'b10, 16'h0000, 16'h0200, rdy, ts);
    ch_valid = '0;
    chk("t6_pre_lock", lock, 1);
    chk("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_lock", lock, 0);
    chk("t6_capture_enable", capture_enable, 1);
    chk("t6_timestamp", timestamp, 0);
    chk("t6_stall", stall_cycles, 0);
    @(negedge clk);
    out_ready = 1'b1;
    mode_oneshot = 1'b0;
    step(2'b01, 16'h0600, 16'h0000, rdy, ts);
    ch_valid = '0;
    chk("t6_post_ready", rdy, 2'b01);
    exp_rec(0, 16'h0600, 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gouram_trace_merge.md
Name: gouram_trace_merge

Overview:
Multi-channel successor to the single-core trace top. It accepts completed trace records from NUM_CHANNELS independent trackers (cores or pipeline trackers) and arbitrates among them round-robin. Each accepted record is stamped with a shared monotonic cycle timestamp and buffered in a FIFO with a valid/ready output. Per-channel repeat (tight-loop) detection either locks capture (one-shot mode) or suppresses repeated records (continuous mode).

Parameters:
NUM_CHANNELS, 2, number of trace source channels (>=1)
ADDR_WIDTH, 16, instruction address width per record
DATA_WIDTH, 32, instruction data width per record
FIFO_DEPTH, 8, output buffer entries (power of two, >=2)
TS_WIDTH, 32, timestamp counter width
REPEAT_LIMIT, 4, consecutive identical addresses on one channel that constitute a repeat (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ch_valid  in  NUM_CHANNELS  record valid per channel
ch_addr  in  NUM_CHANNELS*ADDR_WIDTH  record address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_data  in  NUM_CHANNELS*DATA_WIDTH  record instruction data, packed the same way
ch_ready  out  NUM_CHANNELS  one-hot accept for the current cycle
mode_oneshot  in  1  1 = lock on repeat; 0 = suppress repeats and keep capturing
unlock  in  1  single-cycle pulse that clears lock and all run counters
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts the head
out_addr  out  ADDR_WIDTH  head record address
out_data  out  DATA_WIDTH  head record data
out_chan  out  $clog2(NUM_CHANNELS) (min 1)  source channel of the head record
out_ts  out  TS_WIDTH  timestamp at acceptance
capture_enable  out  1  capture currently permitted
lock  out  1  repeat lock held
stall_cycles  out  16  saturating count of cycles in which a valid channel was refused
timestamp  out  TS_WIDTH  current counter value

Behaviour:
- Reset values: timestamp=0, lock=0, capture_enable=1, out_valid=0, FIFO empty, round-robin pointer=0, all run counters=0, last addresses=0, stall_cycles=0. The out_addr/out_data/out_chan/out_ts values are don't-care while out_valid=0.
- Reset mid-operation discards FIFO contents immediately.
- timestamp increments by 1 every non-reset cycle and wraps modulo 2^TS_WIDTH without any flag.
- can_push = capture_enable && (count<FIFO_DEPTH || (out_valid && out_ready)). A push is therefore allowed on a full FIFO in the same cycle as a pop.
- Arbitration (combinational): when can_push=1, grant the first valid channel at or after rr_ptr, wrapping. ch_ready is one-hot on the granted channel, all-zero otherwise. On a grant, rr_ptr <= granted+1 (mod NUM_CHANNELS).
- Sources hold ch_valid and payload until they see ch_ready.
- stall_cycles increments (saturating at 0xFFFF) in every cycle where |ch_valid && !can_push. Channels that lose arbitration while can_push=1 are not counted.
- Accepted record fields: {addr, data, chan, ts=timestamp in the acceptance cycle}. The record appears at the FIFO head no earlier than the next cycle; on an empty FIFO, out_valid rises exactly one cycle after acceptance.
- Per-channel run tracking on acceptance from channel c:
  - if addr==last_addr[c], run[c] <= run[c]+1, saturating at REPEAT_LIMIT;
  - otherwise run[c] <= 1;
  - last_addr[c] <= addr.
- Repeat event: an acceptance whose post-update run[c] equals REPEAT_LIMIT.
- One-shot mode, on a repeat event:
  - the triggering record is still written;
  - lock <= 1 and capture_enable <= 0 from the next cycle;
  - no further acceptances; the FIFO continues to drain.
- Continuous mode, on any acceptance where the post-update run >= REPEAT_LIMIT: ch_ready still handshakes, but the record is not written (suppressed). The first REPEAT_LIMIT-1 identical records are written; lock stays 0.
- unlock (one cycle):
  - lock <= 0 and capture_enable <= 1 next cycle;
  - all run counters <= 0;
  - last addresses are unchanged.
  - No acceptance can occur in a locked cycle, so unlock never conflicts with a new repeat event.
  - unlock while unlocked only clears run counters.
- A mode_oneshot change takes effect on the next acceptance; it never clears an existing lock.
- FIFO pop: out_valid && out_ready. Simultaneous push and pop keeps the count unchanged, with read/write pointers wrapping at FIFO_DEPTH.

Test Plan:
1. Reset, channel 0 sends addr 0x0100 at cycle 5 (timestamp=5), out_ready=1 -> out_valid in cycle 6 with addr 0x0100, chan 0, ts 5; stall_cycles=0.
2. Channels 0 and 1 valid continuously with distinct addresses, out_ready=1 -> ch_ready alternates 01,10,01,10; FIFO order matches grant order.
3. out_ready=0, channel 0 streams unique addresses -> 8 records accepted, then ch_ready=0 and stall_cycles increments each cycle; raising out_ready for one cycle with ch_valid still high -> one pop plus one push in the same cycle, count stays 8.
4. mode_oneshot=1, channel 1 sends 0x0200 four times -> all four written, lock=1 and capture_enable=0 next cycle; a later channel-0 record gets no ch_ready; unlock pulse -> lock=0, capture resumes, a fifth 0x0200 starts run=1 (written).
5. mode_oneshot=0, channel 0 sends 0x0300 six times -> three records written, last three handshaken but suppressed, lock stays 0; a following 0x0304 is written.
6. Assert rst_n=0 for one cycle with the FIFO holding 5 records and lock=1 -> next cycle out_valid=0, lock=0, capture_enable=1, timestamp=0, stall_cycles=0.
